// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Purpose:
//   Computes WIDTH-bit additions by reusing one 4-bit ripple-carry adder.
//   The adder handles one nibble per clock, least-significant nibble first.
//   The carry is registered between nibbles. Operands arrive on a valid/ready
//   handshake, and the result leaves on a second valid/ready handshake.
//
// Optional feature:
//   Define NSA_SUBTRACT_EN to add the 'sub' input. When sub=1 at accept:
//     - every B nibble is inverted before it reaches the adder;
//     - the carry register starts at 1 and cin is ignored;
//     - the result is sum = a - b mod 2^WIDTH, with cout=1 meaning no borrow.
//   When the macro is undefined, the block only adds.
//
// Ports:
//   clk        in   clock; every state update happens on the rising edge
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   operand source presents a request
//   in_ready   out  block can accept a request (IDLE and not in reset)
//   a, b       in   WIDTH-bit operands, sampled on accept only
//   cin        in   carry into nibble 0, sampled on accept only
//   sub        in   (NSA_SUBTRACT_EN only) subtract select, sampled on accept
//   out_valid  out  sum/cout hold a completed result
//   out_ready  in   consumer takes the result (only looked at in DONE)
//   sum        out  registered WIDTH-bit result
//   cout       out  registered carry out of the top nibble
//   busy       out  high whenever the sequencer is not IDLE
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------

// Team 4-bit ripple-carry adder. The port order (a, b, cin, sum, c4) is
// fixed because callers connect it positionally.
module rippleCarryAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c4
);

  logic [4:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_full_add
      assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c4 = carry[4];

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  // The counter is at least one bit wide so that WIDTH=4 (NIB=1) still works.
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Operands and sum are stored as nibble arrays. The counter then selects a
  // whole nibble directly, with no variable part-select.
  logic [NIB-1:0][3:0] op_a_reg,  op_a_next;
  logic [NIB-1:0][3:0] op_b_reg,  op_b_next;
  logic [NIB-1:0][3:0] sum_reg,   sum_next;
  logic [CW-1:0]       cnt_reg,   cnt_next;
  logic                carry_reg, carry_next;
  logic                cout_reg,  cout_next;
  logic                out_valid_reg, out_valid_next;

  logic       accept;
  logic       last_nib;
  logic       sub_sel;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_c4;

`ifdef NSA_SUBTRACT_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // in_ready depends directly on rst_n, so it drops in the same cycle that
  // reset is asserted, not one cycle later.
  assign in_ready = (state_reg == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;
  assign last_nib = (cnt_reg == LAST_CNT);

  // Single shared adder. During subtract, B is inverted once, at accept, so
  // the RUN datapath is the same for add and subtract.
  assign add_a = op_a_reg[cnt_reg];
  assign add_b = op_b_reg[cnt_reg];

  rippleCarryAdder u_adder (add_a, add_b, carry_reg, add_sum, add_c4);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    op_a_next      = op_a_reg;
    op_b_next      = op_b_reg;
    sum_next       = sum_reg;
    cnt_next       = cnt_reg;
    carry_next     = carry_reg;
    cout_next      = cout_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_a_next  = a;
          op_b_next  = sub_sel ? ~b : b;
          carry_next = sub_sel ? 1'b1 : cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        // Only the active nibble is overwritten. Upper nibbles keep the
        // previous result until their turn comes.
        sum_next[cnt_reg] = add_sum;
        carry_next        = add_c4;
        if (last_nib) begin
          cout_next      = add_c4;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        // Result stays frozen until the consumer takes it. New requests are
        // not seen here because in_ready is low.
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers. Reset clears everything, so a reset that hits in
  // RUN or DONE leaves no partial result behind.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      op_a_reg      <= op_a_next;
      op_b_reg      <= op_b_next;
      sum_reg       <= sum_next;
      cnt_reg       <= cnt_next;
      carry_reg     <= carry_next;
      cout_reg      <= cout_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16). Directed cases
// cover reset, ripple, back-pressure, mid-operation reset and (optionally)
// subtract. These are followed by random operations checked against a
// plain-arithmetic model of a + b + cin (or a - b).
// ---------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

  localparam int W    = 16;
  localparam int NIBS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef NSA_SUBTRACT_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Reference: exact (W+1)-bit arithmetic. Subtract is a + ~b + 1.
  function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc, input logic rs);
    logic [W:0] r;
    if (rs) r = {1'b0, ra} + {1'b0, ~rb} + (W+1)'(1);
    else    r = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. Outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation. 'hold' is the number of cycles out_ready stays
  // low after out_valid rises; in_valid is pulsed during that time to show
  // it is ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input int hold);
    logic [W:0] expv;
    int         lat;
    expv = ref_model(ta, tb_v, tc, ts);
    vectors++;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc;
`ifdef NSA_SUBTRACT_EN
    sub = ts;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();                               // accept edge (edge 0)
    in_valid = 1'b0;
    a   = W'($urandom);                   // operands must not matter after accept
    b   = W'($urandom);
    cin = 1'($urandom);
`ifdef NSA_SUBTRACT_EN
    sub = 1'($urandom);
`endif
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * NIBS + 8) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(NIBS));
    chk("sum", 32'(sum), 32'(expv[W-1:0]));
    chk("cout", 32'(cout), 32'(expv[W]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(expv[W-1:0]));
      chk("hold_cout", 32'(cout), 32'(expv[W]));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();                               // result handshake edge
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d (exp %h/%0d) lat=%0d hold=%0d",
             ta, tb_v, tc, ts, sum, cout, expv[W-1:0], expv[W], lat, hold);
  endtask

  initial begin
    // 1: reset held for 3 cycles with a pending request
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(sum), 32'h0);
      chk("rst_cout", 32'(cout), 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("release_busy", 32'(busy), 32'd0);
    $display("reset sequence done");

    // 2..4: directed operations
    run_op(16'h1236, 16'h0FCC, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h8001, 1'b0, 1'b0, 6);

    // 5: reset in the middle of RUN discards the operation
    vectors++;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    step();                               // accept
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'h0);
    chk("midrst_cout", 32'(cout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    $display("op a=abcd b=1111 aborted by reset");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);

`ifdef NSA_SUBTRACT_EN
    // 6: subtract
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h0009, 16'h0004, 1'b0, 1'b1, 1);
`endif

    // Random operations against the reference model
    for (int n = 0; n < 24; n++) begin
      logic ts;
      ts = 1'b0;
`ifdef NSA_SUBTRACT_EN
      ts = 1'($urandom);
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), ts, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
